// File: rtl/data_mem_pkg.sv
// ============================================================================
//  Module      : data_mem_pkg
//  Description : Shared pipeline constants and memory-op encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_mem_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LW   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LHU  = 4'd3,
        MEM_LB   = 4'd4,
        MEM_LBU  = 4'd5,
        MEM_SW   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SB   = 4'd8
    } mem_op_e;

    localparam int unsigned c_dmem_depth     = 3072;
    localparam logic [31:0] c_dmem_addr_base = 32'h0000_0000;

    function automatic logic is_store(input mem_op_e op);
        return (op == MEM_SW) || (op == MEM_SH) || (op == MEM_SB);
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_load_ext.sv
// ============================================================================
//  Module      : load_ext
//  Description : Selects the loaded lane from a word and sign/zero extends it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_ext
    import data_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  mem_op_e     mem_op,
    output logic [31:0] rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = word[{lane, 3'b000} +: 8];
    assign w_half = lane[1] ? word[31:16] : word[15:0];

    always_comb begin
        rdata = '0;
        case (mem_op)
            MEM_LW:  rdata = word;
            MEM_LH:  rdata = {{16{w_half[15]}}, w_half};
            MEM_LHU: rdata = {16'h0000, w_half};
            MEM_LB:  rdata = {{24{w_byte[7]}}, w_byte};
            MEM_LBU: rdata = {24'h00_0000, w_byte};
            default: rdata = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/data_mem.sv
// ============================================================================
//  Module      : data_mem
//  Description : Word-organised data memory with byte/half/word access and a
//                one-cycle-delayed store log.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH     = c_dmem_depth,
    parameter logic [31:0] ADDR_BASE = c_dmem_addr_base
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  mem_op_e     mem_op,
    output logic [31:0] rdata,
    output logic        err,
    output logic        wlog_valid,
    output logic [31:0] wlog_pc,
    output logic [31:0] wlog_addr,
    output logic [31:0] wlog_data
);

    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]     r_mem [DEPTH];
    logic [31:0]     w_offset;
    logic [29:0]     w_index;
    logic [1:0]      w_lane;
    logic            w_in_range;
    logic [c_aw-1:0] w_idx;
    logic [31:0]     w_word;
    logic [31:0]     w_merged;
    logic [31:0]     w_ext;
    logic            w_store_ok;

    assign w_offset   = addr - ADDR_BASE;
    assign w_index    = w_offset[31:2];
    assign w_lane     = w_offset[1:0];
    assign w_in_range = ({2'b00, w_index} < DEPTH);
    // Out-of-range accesses are flagged; clamp so the array index stays legal.
    assign w_idx      = w_in_range ? w_index[c_aw-1:0] : '0;
    assign w_word     = r_mem[w_idx];

    always_comb begin
        err = 1'b0;
        if (mem_op != MEM_NONE) begin
            if (!w_in_range)
                err = 1'b1;
            else if ((mem_op == MEM_LW || mem_op == MEM_SW) && w_lane != 2'b00)
                err = 1'b1;
            else if ((mem_op == MEM_LH || mem_op == MEM_LHU || mem_op == MEM_SH) && w_lane[0])
                err = 1'b1;
        end
    end

    always_comb begin
        w_merged = w_word;
        case (mem_op)
            MEM_SW: w_merged = wdata;
            MEM_SH: begin
                if (w_lane[1]) w_merged[31:16] = wdata[15:0];
                else           w_merged[15:0]  = wdata[15:0];
            end
            MEM_SB: w_merged[{w_lane, 3'b000} +: 8] = wdata[7:0];
            default: w_merged = w_word;
        endcase
    end

    assign w_store_ok = is_store(mem_op) && !err;

    load_ext u_load_ext (
        .word   (w_word),
        .lane   (w_lane),
        .mem_op (mem_op),
        .rdata  (w_ext)
    );

    assign rdata = err ? 32'h0000_0000 : w_ext;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++)
                r_mem[i] <= '0;
        end else if (w_store_ok) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wlog_valid <= 1'b0;
            wlog_pc    <= '0;
            wlog_addr  <= '0;
            wlog_data  <= '0;
        end else begin
            wlog_valid <= w_store_ok;
            if (w_store_ok) begin
                wlog_pc   <= pc;
                wlog_addr <= ADDR_BASE + {w_index, 2'b00};
                wlog_data <= w_merged;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem.sv
// ============================================================================
//  Module      : tb_data_mem
//  Description : Directed-vector scoreboard bench for data_mem.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem;
    import data_mem_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wdata;
    mem_op_e     mem_op;
    logic [31:0] rdata;
    logic        err;
    logic        wlog_valid;
    logic [31:0] wlog_pc;
    logic [31:0] wlog_addr;
    logic [31:0] wlog_data;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        er;
        logic        wv;
        logic        chk_f;
        logic [31:0] wpc;
        logic [31:0] wad;
        logic [31:0] wdt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    bit   stim_done = 1'b0;

    data_mem dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .addr       (addr),
        .wdata      (wdata),
        .mem_op     (mem_op),
        .rdata      (rdata),
        .err        (err),
        .wlog_valid (wlog_valid),
        .wlog_pc    (wlog_pc),
        .wlog_addr  (wlog_addr),
        .wlog_data  (wlog_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", name, field, act, req);
        end
    endtask

    // Monitor: each cycle's outputs are checked at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.name, "rdata", rdata, e.rd);
            cmp(e.name, "err", {31'b0, err}, {31'b0, e.er});
            cmp(e.name, "wlog_valid", {31'b0, wlog_valid}, {31'b0, e.wv});
            if (e.chk_f) begin
                cmp(e.name, "wlog_pc", wlog_pc, e.wpc);
                cmp(e.name, "wlog_addr", wlog_addr, e.wad);
                cmp(e.name, "wlog_data", wlog_data, e.wdt);
            end
        end
    end

    task automatic vec(input string name, input logic rst, input mem_op_e op,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] p,
                       input logic [31:0] e_rd, input logic e_er, input logic e_wv,
                       input logic e_chk, input logic [31:0] e_pc,
                       input logic [31:0] e_ad, input logic [31:0] e_dt);
        exp_t e;
        @(posedge clk);
        #1;
        reset  = rst;
        mem_op = op;
        addr   = a;
        wdata  = wd;
        pc     = p;
        e.name = name; e.rd = e_rd; e.er = e_er; e.wv = e_wv;
        e.chk_f = e_chk; e.wpc = e_pc; e.wad = e_ad; e.wdt = e_dt;
        exp_q.push_back(e);
    endtask

    initial begin
        reset  = 1'b1;
        mem_op = MEM_NONE;
        addr   = '0;
        wdata  = '0;
        pc     = '0;
        repeat (2) @(posedge clk);

        //   name           rst op       addr          wdata         pc          rdata         err  wv  chk  wlog_pc     wlog_addr     wlog_data
        vec("rst_lw10",     0, MEM_LW,  32'h0000_0010, 32'h0,        32'h0,      32'h0,         0,  0,  1,  32'h0,      32'h0,        32'h0);
        vec("sw4",          0, MEM_SW,  32'h0000_0004, 32'h8765_4321,32'h100,    32'h0,         0,  0,  0,  32'h0,      32'h0,        32'h0);
        vec("lb7",          0, MEM_LB,  32'h0000_0007, 32'h0,        32'h0,      32'hFFFF_FF87, 0,  1,  1,  32'h100,    32'h4,        32'h8765_4321);
        vec("lbu7",         0, MEM_LBU, 32'h0000_0007, 32'h0,        32'h0,      32'h0000_0087, 0,  0,  1,  32'h100,    32'h4,        32'h8765_4321);
        vec("lh4",          0, MEM_LH,  32'h0000_0004, 32'h0,        32'h0,      32'h0000_4321, 0,  0,  0,  32'h0,      32'h0,        32'h0);
        vec("sb5",          0, MEM_SB,  32'h0000_0005, 32'h0000_00AA,32'h104,    32'h0,         0,  0,  0,  32'h0,      32'h0,        32'h0);
        vec("sh6",          0, MEM_SH,  32'h0000_0006, 32'h0000_BEEF,32'h108,    32'h0,         0,  1,  1,  32'h104,    32'h4,        32'h8765_AA21);
        vec("lw4",          0, MEM_LW,  32'h0000_0004, 32'h0,        32'h0,      32'hBEEF_AA21, 0,  1,  1,  32'h108,    32'h4,        32'hBEEF_AA21);
        vec("lh6",          0, MEM_LH,  32'h0000_0006, 32'h0,        32'h0,      32'hFFFF_BEEF, 0,  0,  0,  32'h0,      32'h0,        32'h0);
        vec("lhu6",         0, MEM_LHU, 32'h0000_0006, 32'h0,        32'h0,      32'h0000_BEEF, 0,  0,  0,  32'h0,      32'h0,        32'h0);
        vec("sw2_misal",    0, MEM_SW,  32'h0000_0002, 32'hDEAD_BEEF,32'h10C,    32'h0,         1,  0,  0,  32'h0,      32'h0,        32'h0);
        vec("lh3_misal",    0, MEM_LH,  32'h0000_0003, 32'h0,        32'h0,      32'h0,         1,  0,  1,  32'h108,    32'h4,        32'hBEEF_AA21);
        vec("lw0_nowr",     0, MEM_LW,  32'h0000_0000, 32'h0,        32'h0,      32'h0,         0,  0,  1,  32'h108,    32'h4,        32'hBEEF_AA21);
        vec("sw3000_oor",   0, MEM_SW,  32'h0000_3000, 32'h1234_5678,32'h110,    32'h0,         1,  0,  0,  32'h0,      32'h0,        32'h0);
        vec("lw2ffc",       0, MEM_LW,  32'h0000_2FFC, 32'h0,        32'h0,      32'h0,         0,  0,  1,  32'h108,    32'h4,        32'hBEEF_AA21);
        vec("lw0_oor_nowr", 0, MEM_LW,  32'h0000_0000, 32'h0,        32'h0,      32'h0,         0,  0,  0,  32'h0,      32'h0,        32'h0);
        vec("lw3000_oor",   0, MEM_LW,  32'h0000_3000, 32'h0,        32'h0,      32'h0,         1,  0,  0,  32'h0,      32'h0,        32'h0);
        vec("sw2ffc",       0, MEM_SW,  32'h0000_2FFC, 32'hCAFE_F00D,32'h114,    32'h0,         0,  0,  0,  32'h0,      32'h0,        32'h0);
        vec("lw2ffc_new",   0, MEM_LW,  32'h0000_2FFC, 32'h0,        32'h0,      32'hCAFE_F00D, 0,  1,  1,  32'h114,    32'h2FFC,     32'hCAFE_F00D);
        vec("lb2ffe",       0, MEM_LB,  32'h0000_2FFE, 32'h0,        32'h0,      32'hFFFF_FFFE, 0,  0,  0,  32'h0,      32'h0,        32'h0);
        vec("sw8_reset",    1, MEM_SW,  32'h0000_0008, 32'h0000_0001,32'h118,    32'h0,         0,  0,  1,  32'h114,    32'h2FFC,     32'hCAFE_F00D);
        vec("lw8_cleared",  0, MEM_LW,  32'h0000_0008, 32'h0,        32'h0,      32'h0,         0,  0,  1,  32'h0,      32'h0,        32'h0);
        vec("lw4_cleared",  0, MEM_LW,  32'h0000_0004, 32'h0,        32'h0,      32'h0,         0,  0,  0,  32'h0,      32'h0,        32'h0);
        vec("lw2ffc_clr",   0, MEM_LW,  32'h0000_2FFC, 32'h0,        32'h0,      32'h0,         0,  0,  0,  32'h0,      32'h0,        32'h0);
        vec("none",         0, MEM_NONE,32'h0000_0004, 32'h0,        32'h0,      32'h0,         0,  0,  0,  32'h0,      32'h0,        32'h0);
        stim_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        while ((!stim_done || exp_q.size() != 0) && budget < 200) begin
            @(posedge clk);
            budget++;
        end
        if (exp_q.size() != 0 || !stim_done) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 3072, number of 32-bit words (12 KiB, byte range 0x0000_0000-0x0000_2FFF).
REQ-002 SHALL have parameter ADDR_BASE, default 32'h0000_0000, byte address of word 0.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pc  input  32  PC of the instruction in MEM stage, used only for the write log.
REQ-006 addr  input  32  byte address from EX/MEM ALU result.
REQ-007 wdata  input  32  store data, forwarded rt value.
REQ-008 mem_op  input  4  access type: NONE, LW, LH, LHU, LB, LBU, SW, SH, SB.
REQ-009 rdata  output  32  extended load result, becomes m_Mout for MEM/WB.
REQ-010 err  output  1  access misaligned or out of range.
REQ-011 wlog_valid  output  1  a store committed on the previous edge.
REQ-012 wlog_pc / wlog_addr / wlog_data  output  32 each  PC, word-aligned byte address, merged word of that store.

Function
REQ-013 SHALL compute offset = addr - ADDR_BASE, word index = offset[31:2], lane = offset[1:0].
REQ-014 err SHALL be combinational: 1 when mem_op is not NONE and (index >= DEPTH, or LW/SW with lane != 0, or LH/LHU/SH with lane[0] = 1); else 0.
REQ-015 Loads SHALL read the array combinationally: LW whole word; LH/LHU halfword lane[1] (0 = bits 15:0), sign/zero extended; LB/LBU byte at lane, sign/zero extended.
REQ-016 rdata SHALL be 0 when mem_op is NONE, a store, or err = 1.
REQ-017 Stores SHALL write on the rising edge when mem_op is SW/SH/SB, err = 0 and reset = 0.
REQ-018 SB SHALL replace only byte lane with wdata[7:0]; SH only halfword lane[1] with wdata[15:0]; SW the whole word; other bytes unchanged.
REQ-019 Load of a word stored in the same cycle SHALL return the pre-store value; the new value is visible from the next cycle.
REQ-020 Erroneous stores SHALL leave the array and log unchanged.
REQ-021 Cycle after each committed store: wlog_valid = 1, wlog_pc = pc, wlog_addr = ADDR_BASE + index*4, wlog_data = merged word; otherwise wlog_valid = 0, other log outputs hold.
REQ-022 Back-to-back stores SHALL each produce one single-cycle wlog_valid pulse, in order.

Reset
REQ-023 On reset all DEPTH words SHALL clear to 0 at the edge, overriding a concurrent store.
REQ-024 On reset wlog_valid, wlog_pc, wlog_addr, wlog_data SHALL clear to 0; rdata/err follow REQ-014-016 on the cleared array.
REQ-025 Reset asserted mid-stream SHALL discard the in-flight store with no log pulse.

Structure
REQ-026 mem_op encodings (NONE=0, LW=1, LH=2, LHU=3, LB=4, LBU=5, SW=6, SH=7, SB=8) SHALL live in the shared pipeline package, also used by the controller.
REQ-027 DEPTH default and ADDR_BASE SHALL be package constants.
REQ-028 Load extraction/extension SHALL be one combinational sub-module, load_ext (inputs word, lane, mem_op; output rdata).

Verification
REQ-029 Reset, then LW 0x0000_0010 -> rdata = 0, err = 0, wlog_valid = 0.
REQ-030 SW 0x0000_0004 = 0x8765_4321, next cycle LB 0x0000_0007 -> 0xFFFF_FF87; LBU -> 0x0000_0087; LH 0x0000_0004 -> 0x0000_4321; wlog_valid = 1, wlog_addr = 0x4, wlog_data = 0x8765_4321.
REQ-031 After REQ-030, SB 0x0000_0005 wdata 0x0000_00AA -> word = 0x8765_AA21; SH 0x0000_0006 wdata 0x0000_BEEF -> word = 0xBEEF_AA21.
REQ-032 SW 0x0000_0002 and LH 0x0000_0003 -> err = 1, rdata = 0, no write, no log pulse.
REQ-033 SW 0x0000_3000 (index 3072) -> err = 1, no write; LW 0x0000_2FFC -> err = 0.
REQ-034 SW 0x0000_0008 = 0x1 with reset high same cycle -> word 2 = 0, wlog_valid = 0 next cycle.
